x_token_pkt_fifo: RTL



---
 rtl/x_token_pkg.sv | 18 +
 rtl/x_token_fifo_mem.sv | 23 ++
 rtl/x_token_pkt_fifo.sv | 92 +++++++++
 3 files changed

// File: rtl/x_token_pkg.sv
// Shared token definitions for the packet-aware token FIFO.
// Control codes, default token width and end-of-packet detection.
package x_token_pkg;

  localparam int TOKEN_W = 9;

  localparam logic [7:0] CT_END   = 8'h01;
  localparam logic [7:0] CT_PAUSE = 8'h02;

  // ctl is the token's control flag (its top bit), val its low byte.
  function automatic logic is_eop(
    input logic       ctl,
    input logic [7:0] val
  );
    return ctl && (val == CT_END || val == CT_PAUSE);
  endfunction

endpackage

// File: rtl/x_token_fifo_mem.sv
// DEPTH x WIDTH storage, one synchronous write port, async read port.
// Ports: clk, we/waddr/wdata write side; raddr/rdata read side.
module x_token_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/x_token_pkt_fifo.sv
// First-word fall-through token FIFO that tracks stored end-of-packet tokens.
// Ports: clk, reset, flush; din/wr_en in; dout/rd_en out; status flags,
// count, pkt_count, pkt_avail, overflow/underflow pulses.
module x_token_pkt_fifo
  import x_token_pkg::*;
#(
  parameter int WIDTH    = TOKEN_W,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  input  logic                   wr_en,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] pkt_count,
  output logic                   pkt_avail,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] AF = CW'(AF_LEVEL);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        wr_ok;
  logic        rd_ok;
  logic        eop_in;
  logic        eop_out;

  assign empty = wptr == rptr;
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0])
              && (wptr[AW] != rptr[AW]);

  // Pointers wrap modulo 2*DEPTH, so the difference is the occupancy.
  assign count       = wptr - rptr;
  assign almost_full = count >= AF;
  assign pkt_avail   = pkt_count != '0;

  assign wr_ok = wr_en && !full && !flush;
  assign rd_ok = rd_en && !empty && !flush;

  assign eop_in  = is_eop(din[WIDTH-1], din[7:0]);
  assign eop_out = is_eop(dout[WIDTH-1], dout[7:0]);

  x_token_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_ok && !reset),
    .waddr(wptr[AW-1:0]),
    .wdata(din),
    .raddr(rptr[AW-1:0]),
    .rdata(dout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      pkt_count <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full && !flush;
      underflow <= rd_en && empty && !flush;
      if (flush) begin
        wptr      <= '0;
        rptr      <= '0;
        pkt_count <= '0;
      end else begin
        if (wr_ok) wptr <= wptr + 1'b1;
        if (rd_ok) rptr <= rptr + 1'b1;
        // EOP in and EOP out in one cycle cancel each other.
        if ((wr_ok && eop_in) && !(rd_ok && eop_out))
          pkt_count <= pkt_count + 1'b1;
        else if (!(wr_ok && eop_in) && (rd_ok && eop_out))
          pkt_count <= pkt_count - 1'b1;
      end
    end
  end

endmodule
